mult_share_arbiter: RTL and testbench

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

---
 rtl/mult_arb_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/mult_share_arbiter.sv | 114 +++++++++++
 tb/tb_mult_share_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: FSM state encoding and watchdog length shared by the multiplier-sharing arbiter.
package mult_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    function automatic int timeout_cycles(input int width);
        return 2 * width + 8;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; the search starts at i_ptr and wraps modulo N.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [N-1:0]  w_rot;
    logic [IW-1:0] w_off;
    logic [IW:0]   w_sum;

    // Bit k of w_rot is requester (ptr+k) mod N, so the lowest set bit is the winner.
    assign w_rot = N'({i_req, i_req} >> i_ptr);

    always_comb begin
        w_off = '0;
        o_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IW'(k);
                o_any = 1'b1;
            end
        end
    end

    assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx   = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : IW'(w_sum);
    assign o_grant = o_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one multi-cycle multiplier among NUM_REQ requesters.
// Define MULT_ARB_TIMEOUT_EN to add a WAIT watchdog and the resp_err output.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 32,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_a,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            mult_start,
    output logic [WIDTH-1:0]                mult_a,
    output logic [WIDTH-1:0]                mult_b,
    input  logic                            mult_done,
    input  logic [2*WIDTH-1:0]              mult_product,
    output logic                            resp_valid,
    output logic [IW-1:0]                   resp_id,
    output logic [2*WIDTH-1:0]              resp_result
`ifdef MULT_ARB_TIMEOUT_EN
    ,output logic                           resp_err
`endif
);

    state_t               r_state, w_next;
    logic [IW-1:0]        r_ptr, r_id, w_idx;
    logic [NUM_REQ-1:0]   w_grant;
    logic                 w_any, w_timeout;
    logic [WIDTH-1:0]     r_a, r_b;
    logic [2*WIDTH-1:0]   r_result;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = (mult_done || w_timeout) ? RESP : WAIT;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_id     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_a  <= req_a[w_idx];
                r_b  <= req_b[w_idx];
                r_id <= w_idx;
            end
            if (r_state == WAIT && mult_done) r_result <= mult_product;
            else if (r_state == WAIT && w_timeout) r_result <= '0;
            if (r_state == RESP) r_ptr <= (r_id == IW'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int TO = timeout_cycles(WIDTH);
    localparam int CW = $clog2(TO);

    logic [CW-1:0] r_cnt;
    logic          r_err;

    // Last WAIT cycle is ISSUE+TO-1, so RESP lands exactly TO cycles after ISSUE.
    assign w_timeout = (r_cnt == CW'(TO - 2));
    assign resp_err  = (r_state == RESP) && r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (r_state == ISSUE) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_timeout && !mult_done) r_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign req_ready   = (r_state == IDLE && !rst) ? w_grant : '0;
    assign mult_start  = (r_state == ISSUE);
    assign mult_a      = r_a;
    assign mult_b      = r_b;
    assign resp_valid  = (r_state == RESP);
    assign resp_id     = r_id;
    assign resp_result = r_result;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed scenarios for the shared-multiplier arbiter with a behavioural multiplier.
module tb_mult_share_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NR-1:0]          req_valid;
    logic [NR-1:0][W-1:0]   req_a, req_b;
    logic [NR-1:0]          req_ready;
    logic                   mult_start;
    logic [W-1:0]           mult_a, mult_b;
    logic                   mult_done;
    logic [2*W-1:0]         mult_product;
    logic                   resp_valid;
    logic [1:0]             resp_id;
    logic [2*W-1:0]         resp_result;
`ifdef MULT_ARB_TIMEOUT_EN
    logic                   resp_err;
`endif

    int total = 0, bad = 0, cyc = 0, mcnt = 0, lat = 1, starts = 0, done_cyc = 0, start_cyc = 0;
    bit mdl_en = 1'b1;
    logic [NR-1:0] acc;
    logic [63:0] pa, pb;
    logic [W-1:0] st_a, st_b;
    int g_q[$], gcyc_q[$], rid_q[$], rcyc_q[$];
    logic [63:0] rres_q[$];
    bit rerr_q[$];

    always #5 clk = ~clk;

    mult_share_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .mult_start   (mult_start),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_done    (mult_done),
        .mult_product (mult_product),
        .resp_valid   (resp_valid),
        .resp_id      (resp_id),
        .resp_result  (resp_result)
`ifdef MULT_ARB_TIMEOUT_EN
        ,.resp_err    (resp_err)
`endif
    );

    // One clock: sample 1ns before the rising edge, then update requesters and the multiplier model at the falling edge.
    task automatic tick();
        #4;
        acc = req_ready & req_valid & {NR{~rst}};
        if (!rst) begin
            for (int i = 0; i < NR; i++) if (req_ready[i]) begin g_q.push_back(i); gcyc_q.push_back(cyc); end
            if (mult_start) begin
                starts++;
                start_cyc = cyc;
                st_a = mult_a;
                st_b = mult_b;
                if (mdl_en) begin mcnt = lat; pa = 64'(mult_a); pb = 64'(mult_b); end
            end
            if (resp_valid) begin
                rid_q.push_back(int'(resp_id));
                rres_q.push_back(resp_result);
                rcyc_q.push_back(cyc);
`ifdef MULT_ARB_TIMEOUT_EN
                rerr_q.push_back(resp_err);
`endif
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        req_valid = req_valid & ~acc;
        mult_done = 1'b0;
        if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin mult_done = 1'b1; mult_product = pa * pb; done_cyc = cyc; end
        end
    endtask

    task automatic clear_logs();
        g_q.delete(); gcyc_q.delete(); rid_q.delete(); rcyc_q.delete(); rres_q.delete(); rerr_q.delete();
        starts = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; mult_done = 1'b0; mcnt = 0; mdl_en = 1'b1;
        tick(); tick();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_a = '1; req_b = '1; mult_done = 1'b0; mult_product = '0;
        tick(); tick();
        total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        total++; if (mult_start !== 1'b0) begin bad++; $display("FAIL rst_start: got %b want 0", mult_start); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        total++; if (mult_a !== 32'h0 || mult_b !== 32'h0) begin bad++; $display("FAIL rst_operands: got %h/%h want 0/0", mult_a, mult_b); end
        total++; if (resp_id !== 2'd0 || resp_result !== 64'h0) begin bad++; $display("FAIL rst_resp: got id=%0d res=%h want 0/0", resp_id, resp_result); end
        req_valid = 4'hF;
        #1;
        total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL rst_ready_held: got %b want 0000", req_ready); end
        req_valid = '0;
        rst = 1'b0;
        tick();
        clear_logs();
    endtask

    task automatic test_single();
        do_reset();
        req_a[2] = 32'd7; req_b[2] = 32'd6; lat = 33; req_valid = 4'b0100;
        for (int k = 0; k < 80 && rcyc_q.size() == 0; k++) tick();
        repeat (3) tick();
        total++; if (g_q.size() != 1 || g_q[0] != 2) begin bad++; $display("FAIL single_grant: got n=%0d first=%0d want n=1 first=2", g_q.size(), g_q.size() > 0 ? g_q[0] : -1); end
        total++; if (starts != 1) begin bad++; $display("FAIL single_starts: got %0d want 1", starts); end
        total++; if (st_a !== 32'd7 || st_b !== 32'd6) begin bad++; $display("FAIL single_operands: got %0d/%0d want 7/6", st_a, st_b); end
        total++; if (rid_q.size() != 1 || rid_q[0] != 2) begin bad++; $display("FAIL single_id: got n=%0d id=%0d want n=1 id=2", rid_q.size(), rid_q.size() > 0 ? rid_q[0] : -1); end
        total++; if (rres_q.size() != 1 || rres_q[0] !== 64'd42) begin bad++; $display("FAIL single_result: got %0d want 42", rres_q.size() > 0 ? rres_q[0] : 64'hX); end
        total++; if (rcyc_q.size() != 1 || gcyc_q.size() != 1 || rcyc_q[0] - gcyc_q[0] != 35) begin bad++; $display("FAIL single_latency: got %0d want 35", (rcyc_q.size() > 0 && gcyc_q.size() > 0) ? rcyc_q[0] - gcyc_q[0] : -1); end
    endtask

    task automatic test_all_four();
        int eg[5] = '{0, 1, 2, 3, 0};
        bit rearmed = 1'b0;
        do_reset();
        for (int i = 0; i < NR; i++) begin req_a[i] = 32'(i + 1); req_b[i] = 32'd10; end
        lat = 1; req_valid = 4'hF;
        for (int k = 0; k < 100 && rcyc_q.size() < 5; k++) begin
            tick();
            if (g_q.size() == 1 && !req_valid[0] && !rearmed) begin req_valid[0] = 1'b1; rearmed = 1'b1; end
        end
        for (int i = 0; i < 5; i++) begin
            total++; if (i >= g_q.size() || g_q[i] != eg[i]) begin bad++; $display("FAIL rr_grant[%0d]: got %0d want %0d", i, i < g_q.size() ? g_q[i] : -1, eg[i]); end
            total++; if (i >= rid_q.size() || rid_q[i] != eg[i]) begin bad++; $display("FAIL rr_id[%0d]: got %0d want %0d", i, i < rid_q.size() ? rid_q[i] : -1, eg[i]); end
            total++; if (i >= rres_q.size() || rres_q[i] !== 64'(10 * (eg[i] + 1))) begin bad++; $display("FAIL rr_result[%0d]: got %0d want %0d", i, i < rres_q.size() ? rres_q[i] : 64'hX, 10 * (eg[i] + 1)); end
        end
        for (int i = 1; i < 5; i++) begin
            total++; if (i >= gcyc_q.size() || gcyc_q[i] - gcyc_q[i-1] != 4) begin bad++; $display("FAIL rr_gap[%0d]: got %0d want 4", i, i < gcyc_q.size() ? gcyc_q[i] - gcyc_q[i-1] : -1); end
        end
    endtask

    task automatic test_pending();
        int eg[3] = '{2, 3, 1};
        logic [63:0] er[3] = '{64'd16, 64'd27, 64'd25};
        do_reset();
        lat = 12; req_a[2] = 32'd4; req_b[2] = 32'd4; req_valid = 4'b0100;
        for (int k = 0; k < 10 && starts == 0; k++) tick();
        tick();
        req_a[1] = 32'd5; req_b[1] = 32'd5; req_valid[1] = 1'b1;
        repeat (4) tick();
        req_a[3] = 32'd3; req_b[3] = 32'd9; req_valid[3] = 1'b1;
        for (int k = 0; k < 200 && rcyc_q.size() < 3; k++) tick();
        for (int i = 0; i < 3; i++) begin
            total++; if (i >= g_q.size() || g_q[i] != eg[i]) begin bad++; $display("FAIL pend_grant[%0d]: got %0d want %0d", i, i < g_q.size() ? g_q[i] : -1, eg[i]); end
            total++; if (i >= rres_q.size() || rres_q[i] !== er[i]) begin bad++; $display("FAIL pend_result[%0d]: got %0d want %0d", i, i < rres_q.size() ? rres_q[i] : 64'hX, er[i]); end
        end
    endtask

    task automatic test_reset_wait();
        do_reset();
        mdl_en = 1'b0; req_a[0] = 32'd9; req_b[0] = 32'd9; req_valid = 4'b0001;
        for (int k = 0; k < 10 && starts == 0; k++) tick();
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        tick(); tick();
        mult_product = 64'd81; mult_done = 1'b1;
        tick();
        repeat (8) tick();
        total++; if (rcyc_q.size() != 0) begin bad++; $display("FAIL rstwait_no_resp: got %0d responses want 0", rcyc_q.size()); end
        total++; if (starts != 1) begin bad++; $display("FAIL rstwait_starts: got %0d want 1", starts); end
        total++; if (mult_a !== 32'h0) begin bad++; $display("FAIL rstwait_mult_a: got %h want 0", mult_a); end
        g_q.delete(); gcyc_q.delete();
        req_valid = 4'hF;
        tick();
        total++; if (g_q.size() != 1 || g_q[0] != 0) begin bad++; $display("FAIL rstwait_idle_ptr0: got n=%0d first=%0d want n=1 first=0", g_q.size(), g_q.size() > 0 ? g_q[0] : -1); end
    endtask

    task automatic test_max_operands();
        do_reset();
        req_a[1] = '1; req_b[1] = '1; lat = 2; req_valid = 4'b0010;
        for (int k = 0; k < 40 && rcyc_q.size() == 0; k++) tick();
        total++; if (rid_q.size() != 1 || rid_q[0] != 1) begin bad++; $display("FAIL max_id: got %0d want 1", rid_q.size() > 0 ? rid_q[0] : -1); end
        total++; if (rres_q.size() != 1 || rres_q[0] !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL max_result: got %h want fffffffe00000001", rres_q.size() > 0 ? rres_q[0] : 64'hX); end
    endtask

`ifdef MULT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        mdl_en = 1'b0; req_a[3] = 32'd5; req_b[3] = 32'd5; req_valid = 4'b1000;
        for (int k = 0; k < 120 && rcyc_q.size() == 0; k++) tick();
        total++; if (rerr_q.size() != 1 || rerr_q[0] != 1'b1) begin bad++; $display("FAIL to_err: got n=%0d want one response with err=1", rerr_q.size()); end
        total++; if (rres_q.size() != 1 || rres_q[0] !== 64'h0) begin bad++; $display("FAIL to_result: got %h want 0", rres_q.size() > 0 ? rres_q[0] : 64'hX); end
        total++; if (rcyc_q.size() != 1 || rcyc_q[0] - start_cyc != 72) begin bad++; $display("FAIL to_latency: got %0d want 72", rcyc_q.size() > 0 ? rcyc_q[0] - start_cyc : -1); end
    endtask
`endif

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; mult_done = 1'b0; mult_product = '0;
        test_reset();
        test_single();
        test_all_four();
        test_pending();
        test_reset_wait();
        test_max_operands();
`ifdef MULT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
